// File: rtl/ex_muldiv.sv
// ex_muldiv: EX-stage iterative multiply (shift-add) / divide (restoring) unit for LoongArch
// MUL.W, MULH.W[U], DIV.W[U], MOD.W[U]. Define MD_FAST_MUL_EN for single-cycle multiplies.
module ex_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            cpu_clk,
  input  logic            cpu_rstn,
  input  logic            flush,
  input  logic            valid_in,
  input  logic [2:0]      md_op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [4:0]      wR_in,
  output logic            stall_req,
  output logic            busy,
  output logic            valid_out,
  output logic [XLEN-1:0] result,
  output logic [4:0]      wR_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } md_state_t;

  function automatic logic is_mul(input logic [2:0] op);
    return (op == 3'd1) || (op == 3'd2) || (op == 3'd3);
  endfunction

  function automatic logic is_signed(input logic [2:0] op);
    return (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd5);
  endfunction

  // acc holds the unsigned 64-bit product, or {remainder, quotient} for divides
  function automatic logic [31:0] md_final(input logic [2:0]  op,
                                           input logic [63:0] acc,
                                           input logic        pneg,
                                           input logic        sneg,
                                           input logic        div0);
    logic [63:0] prod;
    logic [31:0] res;
    prod = pneg ? (64'd0 - acc) : acc;
    case (op)
      3'd1:          res = prod[31:0];
      3'd2, 3'd3:    res = prod[63:32];
      3'd4, 3'd6: begin
        if (div0) res = 32'hFFFF_FFFF;
        else if (pneg) res = 32'd0 - acc[31:0];
        else res = acc[31:0];
      end
      3'd5, 3'd7:    res = sneg ? (32'd0 - acc[63:32]) : acc[63:32];
      default:       res = 32'd0;
    endcase
    return res;
  endfunction

  md_state_t          state_r, state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [2:0]         op_r;
  logic [63:0]        acc_r, acc_nxt_s;
  logic [63:0]        mcand_r, mcand_nxt_s;
  logic [31:0]        mplr_r, mplr_nxt_s;
  logic               pneg_r, sneg_r, div0_r;
  logic               busy_r, valid_r;
  logic [XLEN-1:0]    result_r;
  logic [4:0]         wr_r;

  logic               start_s, last_s;
  logic               s1neg_s, s2neg_s;
  logic [31:0]        abs1_s, abs2_s;
  logic [32:0]        shift_s;
  logic               ge_s;
  logic [31:0]        diff_s;

  assign start_s   = valid_in && (md_op != 3'd0) && (state_r == ST_IDLE) && !flush;
  assign last_s    = (cnt_r == CNT_W'(XLEN - 1));
  assign stall_req = !flush && (start_s || (state_r == ST_CALC));
  assign busy      = busy_r;
  assign valid_out = valid_r;
  assign result    = result_r;
  assign wR_out    = wr_r;

  assign s1neg_s = is_signed(md_op) && src1[31];
  assign s2neg_s = is_signed(md_op) && src2[31];
  assign abs1_s  = s1neg_s ? (32'd0 - src1) : src1;
  assign abs2_s  = s2neg_s ? (32'd0 - src2) : src2;

`ifdef MD_FAST_MUL_EN
  logic [63:0] fx1_s, fx2_s, fprod_s;
  logic [31:0] fast_res_s;

  // single-cycle multiply: low 64 bits of the sign/zero-extended 33x33 product
  always_comb begin
    fx1_s      = {{32{s1neg_s}}, src1};
    fx2_s      = {{32{s2neg_s}}, src2};
    fprod_s    = fx1_s * fx2_s;
    fast_res_s = (md_op == 3'd1) ? fprod_s[31:0] : fprod_s[63:32];
  end
`endif

  // one radix-2 step: shift-add for multiplies, restoring subtract for divides
  always_comb begin
    acc_nxt_s   = acc_r;
    mcand_nxt_s = mcand_r;
    mplr_nxt_s  = mplr_r;
    shift_s     = acc_r[63:31];
    ge_s        = (shift_s >= {1'b0, mcand_r[31:0]});
    diff_s      = shift_s[31:0] - mcand_r[31:0];
    if (is_mul(op_r)) begin
      if (mplr_r[0]) acc_nxt_s = acc_r + mcand_r;
      else acc_nxt_s = acc_r;
      mcand_nxt_s = {mcand_r[62:0], 1'b0};
      mplr_nxt_s  = {1'b0, mplr_r[31:1]};
    end else begin
      acc_nxt_s = {(ge_s ? diff_s : shift_s[31:0]), acc_r[30:0], ge_s};
    end
  end

  // next-state logic
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
`ifdef MD_FAST_MUL_EN
            if (is_mul(md_op)) state_nxt_s = ST_DONE;
            else state_nxt_s = ST_CALC;
`else
            state_nxt_s = ST_CALC;
`endif
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_CALC: begin
          if (last_s) state_nxt_s = ST_DONE;
          else state_nxt_s = ST_CALC;
        end
        ST_DONE: state_nxt_s = ST_IDLE;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // state register with registered busy / result strobe
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
      valid_r <= (state_nxt_s == ST_DONE);
    end
  end

  // operand capture, iteration and result latch
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      cnt_r    <= {CNT_W{1'b0}};
      op_r     <= 3'd0;
      acc_r    <= 64'd0;
      mcand_r  <= 64'd0;
      mplr_r   <= 32'd0;
      pneg_r   <= 1'b0;
      sneg_r   <= 1'b0;
      div0_r   <= 1'b0;
      result_r <= {XLEN{1'b0}};
      wr_r     <= 5'd0;
    end else if (start_s) begin
      cnt_r   <= {CNT_W{1'b0}};
      op_r    <= md_op;
      wr_r    <= wR_in;
      pneg_r  <= s1neg_s ^ s2neg_s;
      sneg_r  <= s1neg_s;
      div0_r  <= (src2 == 32'd0);
      if (is_mul(md_op)) begin
        acc_r   <= 64'd0;
        mcand_r <= {32'd0, abs1_s};
        mplr_r  <= abs2_s;
      end else begin
        acc_r   <= {32'd0, abs1_s};
        mcand_r <= {32'd0, abs2_s};
        mplr_r  <= 32'd0;
      end
`ifdef MD_FAST_MUL_EN
      if (is_mul(md_op)) result_r <= fast_res_s;
      else result_r <= result_r;
`endif
    end else if (flush) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_CALC) begin
      cnt_r   <= cnt_r + CNT_W'(1);
      acc_r   <= acc_nxt_s;
      mcand_r <= mcand_nxt_s;
      mplr_r  <= mplr_nxt_s;
      if (last_s) result_r <= md_final(op_r, acc_nxt_s, pneg_r, sneg_r, div0_r);
      else result_r <= result_r;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed self-checking bench for ex_muldiv with a result scoreboard.
module tb_ex_muldiv;

`ifdef MD_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        cpu_clk = 1'b0;
  logic        cpu_rstn;
  logic        flush;
  logic        valid_in;
  logic [2:0]  md_op;
  logic [31:0] src1, src2;
  logic [4:0]  wR_in;
  logic        stall_req, busy, valid_out;
  logic [31:0] result;
  logic [4:0]  wR_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [36:0] sb_q[$];
  int vcyc_q[$];

  ex_muldiv dut (
    .cpu_clk   (cpu_clk),
    .cpu_rstn  (cpu_rstn),
    .flush     (flush),
    .valid_in  (valid_in),
    .md_op     (md_op),
    .src1      (src1),
    .src2      (src2),
    .wR_in     (wR_in),
    .stall_req (stall_req),
    .busy      (busy),
    .valid_out (valid_out),
    .result    (result),
    .wR_out    (wR_out)
  );

  always #5 cpu_clk = ~cpu_clk;

  always @(posedge cpu_clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // scoreboard: every result strobe must match the oldest outstanding expectation
  always @(negedge cpu_clk) begin
    if (cpu_rstn === 1'b1 && valid_out === 1'b1) begin
      vcyc_q.push_back(cyc);
      if (sb_q.size() == 0) begin
        chk("spurious_valid_out", {63'd0, valid_out}, 64'd0);
      end else begin
        logic [36:0] e;
        e = sb_q.pop_front();
        chk("result", {32'd0, result}, {32'd0, e[36:5]});
        chk("wR_out", {59'd0, wR_out}, {59'd0, e[4:0]});
      end
    end
  end

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wr);
    valid_in = 1'b1;
    md_op    = op;
    src1     = a;
    src2     = b;
    wR_in    = wr;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wr,
                        input logic [31:0] exp, input int lat);
    int n;
    n = 0;
    issue(op, a, b, wr);
    sb_q.push_back({exp, wr});
    #1;
    while (stall_req && n < 100) begin
      tick();
      valid_in = 1'b0;
      md_op    = 3'd0;
      #1;
      n++;
    end
    chk({tag, "_stall_cycles"}, 64'(n), 64'(lat));
    chk({tag, "_done_valid"}, {63'd0, valid_out}, 64'd1);
    chk({tag, "_done_busy"}, {63'd0, busy}, 64'd1);
    tick();
    chk({tag, "_idle_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_idle_valid"}, {63'd0, valid_out}, 64'd0);
  endtask

  initial begin
    cpu_rstn = 1'b0;
    flush    = 1'b0;
    valid_in = 1'b0;
    md_op    = 3'd0;
    src1     = 32'd0;
    src2     = 32'd0;
    wR_in    = 5'd0;
    tick();
    tick();
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_valid", {63'd0, valid_out}, 64'd0);
    chk("rst_result", {32'd0, result}, 64'd0);
    chk("rst_wr", {59'd0, wR_out}, 64'd0);
    chk("rst_stall", {63'd0, stall_req}, 64'd0);
    cpu_rstn = 1'b1;
    tick();

    run_op("mul_w", 3'd1, 32'hFFFF_FFFD, 32'd7, 5'd5, 32'hFFFF_FFEB, MUL_LAT);
    run_op("mulh_wu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, MUL_LAT);
    run_op("mulh_w", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0000, MUL_LAT);
    run_op("mulh_w_mix", 3'd2, 32'h8000_0000, 32'd3, 5'd8, 32'hFFFF_FFFE, MUL_LAT);
    run_op("div_w", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD, DIV_LAT);
    run_op("mod_w", 3'd5, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF, DIV_LAT);
    run_op("div_wu", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd12, 32'h7FFF_FFFC, DIV_LAT);
    run_op("mod_wu", 3'd7, 32'hFFFF_FFF9, 32'd2, 5'd13, 32'h0000_0001, DIV_LAT);
    run_op("div_w_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, DIV_LAT);
    run_op("mod_w_ovf", 3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h0000_0000, DIV_LAT);
    run_op("div_wu_z", 3'd6, 32'd5, 32'd0, 5'd16, 32'hFFFF_FFFF, DIV_LAT);
    run_op("mod_wu_z", 3'd7, 32'd5, 32'd0, 5'd17, 32'd5, DIV_LAT);
    run_op("div_w_z", 3'd4, 32'hFFFF_FFF9, 32'd0, 5'd18, 32'hFFFF_FFFF, DIV_LAT);
    run_op("mod_w_z", 3'd5, 32'hFFFF_FFF9, 32'd0, 5'd19, 32'hFFFF_FFF9, DIV_LAT);

    // flush a divide at CALC cycle 10; it must never produce a strobe
    issue(3'd4, 32'd1000, 32'd3, 5'd20);
    tick();
    valid_in = 1'b0;
    md_op    = 3'd0;
    for (int i = 0; i < 10; i++) tick();
    flush = 1'b1;
    #1;
    chk("flush_stall", {63'd0, stall_req}, 64'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    chk("flush_valid", {63'd0, valid_out}, 64'd0);
    chk("flush_idle_stall", {63'd0, stall_req}, 64'd0);
    run_op("mul_after_flush", 3'd1, 32'd6, 32'd7, 5'd21, 32'd42, MUL_LAT);

    // asynchronous reset at CALC cycle 20, asserted mid-clock
    issue(3'd6, 32'd999, 32'd4, 5'd9);
    tick();
    valid_in = 1'b0;
    md_op    = 3'd0;
    for (int i = 0; i < 20; i++) tick();
    #2;
    cpu_rstn = 1'b0;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_valid", {63'd0, valid_out}, 64'd0);
    chk("arst_result", {32'd0, result}, 64'd0);
    chk("arst_wr", {59'd0, wR_out}, 64'd0);
    chk("arst_stall", {63'd0, stall_req}, 64'd0);
    tick();
    cpu_rstn = 1'b1;
    tick();

    vcyc_q.delete();
    run_op("div_wu_100_7", 3'd6, 32'd100, 32'd7, 5'd22, 32'd14, DIV_LAT);
    run_op("mod_wu_100_7", 3'd7, 32'd100, 32'd7, 5'd23, 32'd2, DIV_LAT);
    chk("b2b_strobes", 64'(vcyc_q.size()), 64'd2);
    if (vcyc_q.size() == 2) chk("b2b_spacing", 64'(vcyc_q[1] - vcyc_q[0]), 64'd34);

    for (int i = 0; i < 5; i++) tick();
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Execute-stage iterative multiply/divide unit. Consumes the decoded operands and destination held in the ID/EX pipeline register.
- Raises a stall request that freezes the front end (PC, IF/ID, ID/EX `suspend`) while an operation runs.
- Presents a single-cycle result strobe to the EX/MEM write-back select.
- Covers LoongArch MUL.W, MULH.W, MULH.WU, DIV.W, MOD.W, DIV.WU and MOD.WU.

Parameters:
- XLEN, 32, operand width. Only 32 is supported.
- CNT_W, 6, iteration counter width. Must hold XLEN.

Ports:
- cpu_clk  in  1  pipeline clock; all state changes on rising edge.
- cpu_rstn  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous kill of any in-flight operation (branch redirect/exception).
- valid_in  in  1  instruction in EX is valid.
- md_op  in  3  0 none, 1 MUL.W, 2 MULH.W, 3 MULH.WU, 4 DIV.W, 5 MOD.W, 6 DIV.WU, 7 MOD.WU.
- src1  in  32  rj operand (dividend / multiplicand).
- src2  in  32  rk operand (divisor / multiplier).
- wR_in  in  5  destination register.
- stall_req  out  1  hold upstream stages; combinational.
- busy  out  1  registered; high in CALC and DONE.
- valid_out  out  1  result strobe, one cycle.
- result  out  32  operation result.
- wR_out  out  5  destination, latched at start.

Behaviour:
- Definition: start = valid_in && md_op!=0 && state==IDLE && !flush.
- FSM has three states: IDLE, CALC, DONE.
  - IDLE->CALC on start. The edge latches md_op, wR_in, abs/raw operands and sign flags, and clears cnt.
  - CALC: one radix-2 step per cycle, cnt++. When cnt==XLEN-1, the edge goes to DONE.
  - DONE: valid_out=1, result driven, start ignored. Next edge goes to IDLE.
- stall_req = !flush && (start || state==CALC). It is low in DONE, so ID/EX advances on the DONE edge and no re-issue occurs.
- Latency: 1 accept cycle + 32 CALC cycles + DONE. stall_req is high for 33 cycles and valid_out is on the 34th cycle.
- Multiply:
  - Unsigned shift-add over |src1|,|src2| (raw values for MULH.WU), 64-bit accumulator.
  - Signed ops negate the 64-bit product if the operand signs differ.
  - MUL.W returns bits [31:0]; MULH.W and MULH.WU return bits [63:32].
- Divide:
  - Restoring, unsigned, on |src1|,|src2| (raw values for the .WU ops).
  - Quotient is negated if the signs differ. Remainder takes the sign of src1.
  - DIV.* returns the quotient; MOD.* returns the remainder.
- Divide by zero (src2==0), no stall shortening:
  - Quotient = 0xFFFFFFFF.
  - Remainder = src1 (raw).
- Signed overflow, 0x80000000 / 0xFFFFFFFF:
  - Quotient = 0x80000000.
  - Remainder = 0.
- flush: in any state, the next edge goes to IDLE and clears cnt. valid_out is not asserted for the killed op. flush in DONE suppresses the next-cycle effect only; the current-cycle valid_out is still seen combinationally by EX/MEM, which is flushed by the same signal.
- Reset, including mid-operation: state=IDLE, cnt=0, busy=0, valid_out=0, result=0, wR_out=0. stall_req evaluates to 0 while reset is held, because valid_in is low.
- result and wR_out hold their last values outside DONE. Downstream must qualify them with valid_out.

Optional Feature:
- MD_FAST_MUL_EN, when defined: multiplies (md_op 1-3) use a single-cycle 33x33 signed multiplier.
  - IDLE->DONE directly on start.
  - stall_req is high only in the accept cycle.
  - valid_out is on the 2nd cycle.
  - Divides are unchanged.
- When undefined: multiplies use the 32-cycle iterative path described above.

Test Plan:
- MUL.W src1=0xFFFFFFFD(-3), src2=7 -> after 33 stall cycles, valid_out=1 with result 0xFFFFFFEB and wR_out as issued. stall_req then falls and busy clears one cycle later.
- MULH.WU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULH.W same operands -> 0x00000000. With MD_FAST_MUL_EN, the same values appear with valid_out on cycle 2.
- DIV.W -7/2 -> 0xFFFFFFFD. MOD.W -7/2 -> 0xFFFFFFFF. DIV.WU 0xFFFFFFF9/2 -> 0x7FFFFFFC. MOD.WU -> 1.
- Boundaries:
  - DIV.W 0x80000000/0xFFFFFFFF -> 0x80000000.
  - MOD.W same operands -> 0.
  - DIV.WU 5/0 -> 0xFFFFFFFF.
  - MOD.WU 5/0 -> 5.
- Start DIV.W, assert flush at CALC cycle 10 -> stall_req drops in the same cycle, IDLE next cycle, no valid_out. A new MUL.W issued immediately after completes normally.
- Deassert cpu_rstn asynchronously at CALC cycle 20 (mid-clock) -> busy, valid_out, result and wR_out are 0 immediately. After release, a back-to-back DIV.WU 100/7 then MOD.WU 100/7 yields 14 then 2 in consecutive valid_out pulses, 34 cycles apart.
